// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int DEFAULT_PC_STEP = 4;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, clear (flush) and kill (bubble) controls
module if_id_reg
    import ifu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_kill,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_instr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_instr
);
    // Clear flushes the instruction to NOP; kill only drops valid and keeps the fields
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_pc    <= '0;
            o_instr <= '0;
        end else if (i_clear) begin
            o_valid <= 1'b0;
            o_instr <= DATA_W'(NOP_INSTR);
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_pc    <= i_pc;
            o_instr <= i_instr;
        end else if (i_kill) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and instruction memory master with freeze skid and branch redirect
module if_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_freeze,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_addr,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic              o_if_id_valid,
    output logic [ADDR_W-1:0] o_if_id_pc,
    output logic [DATA_W-1:0] o_if_id_instr
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [DATA_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_ld_pc;
    logic [DATA_W-1:0] w_ld_instr;
    logic              w_fire;
    logic              w_load;
    logic              w_kill;
    logic              w_skid_ld;

    assign o_imem_req  = (r_state == FETCH);
    assign o_imem_addr = r_pc;

    // Branch beats freeze beats normal flow; a fetch landing under freeze is parked in the skid
    always_comb begin
        w_fire      = (r_state == FETCH) && i_imem_ready;
        w_pc_inc    = r_pc + ADDR_W'(PC_STEP);
        w_state_nxt = i_branch_taken ? FETCH :
                      (r_state == FETCH) ? ((w_fire && i_freeze) ? HOLD : FETCH) :
                      (i_freeze ? HOLD : FETCH);
        w_load      = !i_branch_taken && !i_freeze && (w_fire || r_state == HOLD);
        w_kill      = !i_branch_taken && !i_freeze && (r_state == FETCH) && !i_imem_ready;
        w_skid_ld   = !i_branch_taken && w_fire && i_freeze;
        w_ld_pc     = (r_state == HOLD) ? r_skid_pc : w_pc_inc;
        w_ld_instr  = (r_state == HOLD) ? r_skid_instr : i_imem_rdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_branch_taken) begin
                r_pc         <= i_branch_addr;
                r_skid_pc    <= '0;
                r_skid_instr <= '0;
            end else begin
                if (w_fire)
                    r_pc <= w_pc_inc;
                if (w_skid_ld) begin
                    r_skid_pc    <= w_pc_inc;
                    r_skid_instr <= i_imem_rdata;
                end
            end
        end
    end

    if_id_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_id (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_clear (i_branch_taken),
        .i_kill  (w_kill),
        .i_pc    (w_ld_pc),
        .i_instr (w_ld_instr),
        .o_valid (o_if_id_valid),
        .o_pc    (o_if_id_pc),
        .o_instr (o_if_id_instr)
    );
endmodule
